spi_master_tx_fifo: RTL and testbench
=====================================

// Module: spi_master_tx_fifo
// PURPOSE
//  Word FIFO that buffers 32-bit TX words between the register/AXI write path and the SPI TX shifter.
//  Upstream writes with valid/ready. Downstream is the shifter, which pulls words on its data_valid/data_ready pair.
//  Output is show-ahead (first-word visible), so the shifter can take a word in the same cycle it asserts ready.
//  Also exposes fill level and an almost-empty flag, used for the TX interrupt and status register.
// PARAMETERS
//  DATA_WIDTH        32  word width in bits
//  BUFFER_DEPTH      8   number of entries; any value >= 2, need not be a power of two
//  LOG_BUFFER_DEPTH  $clog2(BUFFER_DEPTH)  pointer width
//  ALMOST_EMPTY_LVL  2   almost_empty asserts when elements <= this value
// PORTS
//  clk           in   1                     system clock, all logic on posedge
//  rstn          in   1                     asynchronous active-low reset
//  clear         in   1                     synchronous flush (SPI command abort / new transfer)
//  data_in       in   DATA_WIDTH            write word
//  valid_in      in   1                     write request
//  ready_out     out  1                     FIFO can accept a word (not full)
//  data_out      out  DATA_WIDTH            head word (show-ahead)
//  valid_out     out  1                     head word valid (not empty)
//  ready_in      in   1                     downstream consumes head word this cycle
//  elements      out  LOG_BUFFER_DEPTH+1    current fill level, 0..BUFFER_DEPTH
//  almost_empty  out  1                     elements <= ALMOST_EMPTY_LVL
// BEHAVIOUR
//  Reset (rstn low, async):
//   - rd_ptr, wr_ptr and elements go to 0; storage is cleared to 0.
//   - Outputs: ready_out=1, valid_out=0, data_out=0, elements=0, almost_empty=1.
//  Handshakes:
//   - push = valid_in & ready_out.
//   - pop = valid_out & ready_in.
//   - ready_out = (elements != BUFFER_DEPTH).
//   - valid_out = (elements != 0).
//   - ready_out and valid_out depend only on state registers, with no combinational path from the inputs.
//  Push: mem[wr_ptr] <= data_in; wr_ptr advances.
//  Pop: rd_ptr advances; the next entry appears on data_out in the following cycle.
//  data_out = mem[rd_ptr] (combinational read). It is don't-care while valid_out=0, but must be stable while valid_out=1 and no pop occurs.
//  Latency: a word pushed in cycle N is visible with valid_out=1 in cycle N+1. There is no empty fall-through bypass.
//  Pointer wrap: a pointer equal to BUFFER_DEPTH-1 wraps to 0 on advance. This is explicit compare-and-wrap, not modulo 2^n.
//  Level update:
//   - push only: elements +1.
//   - pop only: elements -1.
//   - push and pop together: elements unchanged, both pointers advance.
//  Boundary conditions:
//   - Full: ready_out=0 and push is blocked even if a pop happens in the same cycle. No full bypass; ready_out rises the cycle after the pop.
//   - Empty: valid_out=0, so pop cannot occur. ready_in while empty is ignored.
//   - elements never exceeds BUFFER_DEPTH and never underflows.
//  clear:
//   - Next cycle: pointers=0, elements=0.
//   - clear overrides any push or pop in the same cycle; the pushed word is dropped.
//   - Storage contents are not required to be cleared.
//  Reset mid-transfer: all state is dropped immediately (async). Upstream and downstream must re-handshake after rstn rises.
//  almost_empty is combinational from the registered elements value.
// TESTING
//  1. Reset, then push 0xA0000000..0xA0000007 on 8 consecutive cycles, ready_in=0 -> elements 1..8; ready_out=0 after the 8th push; almost_empty drops when elements=3.
//  2. From full, hold ready_in=1 -> data_out is 0xA0000000..0xA0000007 in order, one word per cycle; valid_out=0 and elements=0 after the 8th pop.
//  3. At elements=3, push and pop together for 5 cycles -> elements stays 3; words come out in FIFO order with none lost or duplicated.
//  4. At full, assert valid_in and ready_in together -> pop only, elements=7; the push is accepted in the next cycle.
//  5. elements=5 with clear, valid_in and ready_in all high -> next cycle elements=0, valid_out=0; a following push 0x12345678 is read back first.
//  6. BUFFER_DEPTH=6: push/pop 20 words streaming -> pointers wrap at 5->0 and the data sequence is preserved. Pulse rstn low mid-stream -> outputs return to reset values asynchronously.

Source files
------------

// File: rtl/spi_master_tx_fifo_if.sv
// Handshake bundle between the TX word FIFO, its upstream writer and the SPI shifter.
// slave = FIFO side, master = the environment driving writes and pulling words.
interface spi_master_tx_fifo_if #(
    parameter int unsigned DATA_WIDTH       = 32,
    parameter int unsigned BUFFER_DEPTH     = 8,
    parameter int unsigned LOG_BUFFER_DEPTH = $clog2(BUFFER_DEPTH)
) ();
    logic [DATA_WIDTH-1:0]     data_in;
    logic                      valid_in;
    logic                      ready_out;
    logic [DATA_WIDTH-1:0]     data_out;
    logic                      valid_out;
    logic                      ready_in;
    logic [LOG_BUFFER_DEPTH:0] elements;
    logic                      almost_empty;

    modport slave (
        input  data_in,
        input  valid_in,
        input  ready_in,
        output ready_out,
        output data_out,
        output valid_out,
        output elements,
        output almost_empty
    );

    modport master (
        output data_in,
        output valid_in,
        output ready_in,
        input  ready_out,
        input  data_out,
        input  valid_out,
        input  elements,
        input  almost_empty
    );
endinterface

// File: rtl/spi_master_tx_fifo.sv
// Show-ahead word FIFO buffering TX words for the SPI shifter, with fill level and almost-empty status.
// Depth need not be a power of two; pointers wrap explicitly at BUFFER_DEPTH-1.
module spi_master_tx_fifo #(
    parameter int unsigned DATA_WIDTH       = 32,
    parameter int unsigned BUFFER_DEPTH     = 8,
    parameter int unsigned LOG_BUFFER_DEPTH = $clog2(BUFFER_DEPTH),
    parameter int unsigned ALMOST_EMPTY_LVL = 2
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                clear,
    spi_master_tx_fifo_if.slave bus
);
    localparam logic [LOG_BUFFER_DEPTH-1:0] LAST_PTR = LOG_BUFFER_DEPTH'(BUFFER_DEPTH - 1);
    localparam logic [LOG_BUFFER_DEPTH:0]   FULL_LVL = (LOG_BUFFER_DEPTH + 1)'(BUFFER_DEPTH);
    localparam logic [LOG_BUFFER_DEPTH:0]   AE_LVL   = (LOG_BUFFER_DEPTH + 1)'(ALMOST_EMPTY_LVL);

    logic [DATA_WIDTH-1:0]       r_mem [BUFFER_DEPTH];
    logic [LOG_BUFFER_DEPTH-1:0] r_rd_ptr;
    logic [LOG_BUFFER_DEPTH-1:0] r_wr_ptr;
    logic [LOG_BUFFER_DEPTH:0]   r_elements;

    logic w_ready;
    logic w_valid;
    logic w_push;
    logic w_pop;

    function automatic logic [LOG_BUFFER_DEPTH-1:0] f_next_ptr(input logic [LOG_BUFFER_DEPTH-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Flags come from the registered level only, so no input reaches ready/valid combinationally.
    assign w_ready = (r_elements != FULL_LVL);
    assign w_valid = (r_elements != '0);
    assign w_push  = bus.valid_in & w_ready;
    assign w_pop   = w_valid & bus.ready_in;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < BUFFER_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push && !clear) begin
            r_mem[r_wr_ptr] <= bus.data_in;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_elements <= '0;
        end else if (clear) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_elements <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= f_next_ptr(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= f_next_ptr(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_elements <= r_elements + 1'b1;
                2'b01:   r_elements <= r_elements - 1'b1;
                default: r_elements <= r_elements;
            endcase
        end
    end

    assign bus.ready_out    = w_ready;
    assign bus.valid_out    = w_valid;
    assign bus.data_out     = r_mem[r_rd_ptr];
    assign bus.elements     = r_elements;
    assign bus.almost_empty = (r_elements <= AE_LVL);
endmodule

// File: tb/tb_spi_master_tx_fifo.sv
// Scoreboard bench: depth-8 and depth-6 FIFOs share one stimulus stream, each checked against a queue model.
module tb_spi_master_tx_fifo;
    logic        clk      = 1'b0;
    logic        rstn     = 1'b0;
    logic        clear    = 1'b0;
    logic        valid_in = 1'b0;
    logic        ready_in = 1'b0;
    logic [31:0] data_in  = '0;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    function automatic void chk(input string nm, input longint unsigned act, input longint unsigned exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    task automatic drive(input logic v, input logic [31:0] d, input logic r, input logic c);
        valid_in = v;
        data_in  = d;
        ready_in = r;
        clear    = c;
        @(posedge clk);
        #1;
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int unsigned D = (g == 0) ? 8 : 6;

        logic [31:0] exp_q[$];
        int          cnt;

        spi_master_tx_fifo_if #(.DATA_WIDTH(32), .BUFFER_DEPTH(D)) bus ();

        assign bus.data_in  = data_in;
        assign bus.valid_in = valid_in;
        assign bus.ready_in = ready_in;

        spi_master_tx_fifo #(
            .DATA_WIDTH      (32),
            .BUFFER_DEPTH    (D),
            .ALMOST_EMPTY_LVL(2)
        ) u_dut (
            .clk  (clk),
            .rstn (rstn),
            .clear(clear),
            .bus  (bus)
        );

        // Reference: a word is accepted whenever the level is below depth, taken whenever nonzero.
        always @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                cnt = 0;
                exp_q.delete();
            end else if (clear) begin
                cnt = 0;
                exp_q.delete();
            end else begin
                if (valid_in && cnt != int'(D) && ready_in && cnt != 0) begin
                    exp_q.push_back(data_in);
                end else if (valid_in && cnt != int'(D)) begin
                    exp_q.push_back(data_in);
                    cnt++;
                end else if (ready_in && cnt != 0) begin
                    cnt--;
                end
            end
        end

        always @(negedge clk) begin
            if (rstn) begin
                chk($sformatf("d%0d_elements", D), 64'(bus.elements), 64'(cnt));
                chk($sformatf("d%0d_ready_out", D), 64'(bus.ready_out), 64'(cnt < int'(D)));
                chk($sformatf("d%0d_valid_out", D), 64'(bus.valid_out), 64'(cnt > 0));
                chk($sformatf("d%0d_almost_empty", D), 64'(bus.almost_empty), 64'(cnt <= 2));
                if (bus.valid_out && ready_in) begin
                    if (exp_q.size() == 0) begin
                        chk($sformatf("d%0d_unexpected_word", D), 64'(bus.data_out), 64'd0 - 64'd1);
                    end else begin
                        chk($sformatf("d%0d_data_out", D), 64'(bus.data_out), 64'(exp_q.pop_front()));
                    end
                end
            end
        end

        always @(negedge rstn) begin
            #1;
            chk($sformatf("d%0d_rst_ready_out", D), 64'(bus.ready_out), 64'd1);
            chk($sformatf("d%0d_rst_valid_out", D), 64'(bus.valid_out), 64'd0);
            chk($sformatf("d%0d_rst_data_out", D), 64'(bus.data_out), 64'd0);
            chk($sformatf("d%0d_rst_elements", D), 64'(bus.elements), 64'd0);
            chk($sformatf("d%0d_rst_almost_empty", D), 64'(bus.almost_empty), 64'd1);
        end
    end

    initial begin
        repeat (2) drive(1'b0, '0, 1'b0, 1'b0);
        rstn = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0);

        // Fill with no reads, then drain in order.
        for (int i = 0; i < 8; i++) drive(1'b1, 32'hA000_0000 + 32'(i), 1'b0, 1'b0);
        repeat (9) drive(1'b0, '0, 1'b1, 1'b0);

        // Steady level under simultaneous push and pop.
        for (int i = 0; i < 3; i++) drive(1'b1, 32'hB000_0000 + 32'(i), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) drive(1'b1, 32'hB000_0010 + 32'(i), 1'b1, 1'b0);

        // Full with push and pop requested together, then the retried push.
        for (int i = 0; i < 6; i++) drive(1'b1, 32'hC000_0000 + 32'(i), 1'b0, 1'b0);
        drive(1'b1, 32'hC000_0010, 1'b1, 1'b0);
        drive(1'b1, 32'hC000_0011, 1'b0, 1'b0);

        // Clear overriding push and pop.
        repeat (10) drive(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) drive(1'b1, 32'hD000_0000 + 32'(i), 1'b0, 1'b0);
        drive(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1);
        drive(1'b1, 32'h1234_5678, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0);

        // Random streaming with a mid-stream asynchronous reset pulse between clock edges.
        for (int n = 0; n < 400; n++) begin
            if (n == 200) begin
                valid_in = 1'b1;
                data_in  = $urandom;
                ready_in = 1'b1;
                clear    = 1'b0;
                #1 rstn = 1'b0;
                #2 rstn = 1'b1;
                @(posedge clk);
                #1;
            end else if (n < 100) begin
                drive($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) == 0, $urandom_range(0, 59) == 0);
            end else begin
                drive($urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 2) != 0, $urandom_range(0, 49) == 0);
            end
        end
        repeat (12) drive(1'b0, '0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
